// File: rtl/divide_unit.sv
// Radix-2 restoring divider for RV32M div/divu/rem/remu: one quotient bit per cycle,
// 32 cycles accept-to-done for normal ops, 1 cycle for divide-by-zero and signed overflow.
module divide_unit (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  input  logic        DIV_start,
  input  logic        DIV_cancel,
  input  logic [1:0]  DIV_op,
  input  logic [31:0] DIV_dividend,
  input  logic [31:0] DIV_divisor,
  output logic        DIV_busy,
  output logic        DIV_done,
  output logic [31:0] DIV_result
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [32:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        is_signed;
  logic [31:0] a_mag, b_mag;
  logic        div_zero, ovf;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        no_borrow;
  logic [32:0] rem_nx;
  logic [31:0] quo_nx;
  logic [31:0] q_fix, r_fix;
  logic        unused_bits;

  // Magnitudes for signed ops; 0x80000000 negates to itself, i.e. unsigned 2^31.
  assign is_signed = ~DIV_op[0];
  assign a_mag     = (is_signed && DIV_dividend[31]) ? (32'd0 - DIV_dividend) : DIV_dividend;
  assign b_mag     = (is_signed && DIV_divisor[31])  ? (32'd0 - DIV_divisor)  : DIV_divisor;
  assign div_zero  = (DIV_divisor == 32'd0);
  assign ovf       = is_signed && (DIV_dividend == 32'h8000_0000) && (DIV_divisor == 32'hFFFF_FFFF);

  assign shifted   = {rem_q[31:0], quo_q[31]};
  assign diff      = {1'b0, shifted} - {2'b00, dsr_q};
  assign no_borrow = ~diff[33];
  assign rem_nx    = no_borrow ? diff[32:0] : shifted;
  assign quo_nx    = {quo_q[30:0], no_borrow};

  assign q_fix = (qneg_q && !op_q[0]) ? (32'd0 - quo_nx)       : quo_nx;
  assign r_fix = (rneg_q && !op_q[0]) ? (32'd0 - rem_nx[31:0]) : rem_nx[31:0];

  // The kept remainder is always below the divisor, so its top bit stays zero.
  assign unused_bits = ^{rem_q[32], rem_nx[32]};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (DIV_start && !DIV_cancel) begin
          op_d   = DIV_op;
          qneg_d = DIV_dividend[31] ^ DIV_divisor[31];
          rneg_d = DIV_dividend[31];
          cnt_d  = 5'd0;
          if (div_zero) begin
            res_d   = DIV_op[1] ? DIV_dividend : 32'hFFFF_FFFF;
            state_d = S_DONE;
          end else if (ovf) begin
            res_d   = DIV_op[1] ? 32'd0 : 32'h8000_0000;
            state_d = S_DONE;
          end else begin
            rem_d   = 33'd0;
            quo_d   = a_mag;
            dsr_d   = b_mag;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (DIV_cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            res_d   = op_q[1] ? r_fix : q_fix;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      rem_q   <= 33'd0;
      quo_q   <= 32'd0;
      dsr_q   <= 32'd0;
      res_q   <= 32'd0;
      cnt_q   <= 5'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign DIV_busy   = (state_q != S_IDLE);
  assign DIV_done   = (state_q == S_DONE);
  assign DIV_result = res_q;

endmodule

// File: tb/tb_divide_unit.sv
// Randomized + directed bench for divide_unit against an arithmetic reference model.
module tb_divide_unit;
  logic        SYS_clk = 1'b0;
  logic        SYS_reset = 1'b1;
  logic        DIV_start = 1'b0;
  logic        DIV_cancel = 1'b0;
  logic [1:0]  DIV_op = 2'd0;
  logic [31:0] DIV_dividend = 32'd0;
  logic [31:0] DIV_divisor = 32'd0;
  logic        DIV_busy;
  logic        DIV_done;
  logic [31:0] DIV_result;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          exp_lat = 0;
  logic [31:0] exp_res = 32'd0;
  logic [31:0] held = 32'd0;
  bit          exp_pending = 1'b0;

  divide_unit dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .DIV_start(DIV_start), .DIV_cancel(DIV_cancel),
    .DIV_op(DIV_op), .DIV_dividend(DIV_dividend), .DIV_divisor(DIV_divisor),
    .DIV_busy(DIV_busy), .DIV_done(DIV_done), .DIV_result(DIV_result)
  );

  always #5 SYS_clk = ~SYS_clk;
  always @(posedge SYS_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'd0:    return sa / sb;
      2'd1:    return a / b;
      2'd2:    return sa % sb;
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Every cycle: a done must be expected and carry the expected value; otherwise result holds.
  always @(negedge SYS_clk) begin
    if (DIV_done) begin
      chk("done_expected", {31'd0, exp_pending}, 32'd1);
      if (exp_pending) begin
        chk("result", DIV_result, exp_res);
        held = exp_res;
        exp_pending = 1'b0;
      end
    end else begin
      chk("result_hold", DIV_result, held);
    end
  end

  task automatic set_exp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r);
    exp_res     = r;
    exp_pending = 1'b1;
    exp_lat     = is_special(op, a, b) ? 0 : 32;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r);
    DIV_op       = op;
    DIV_dividend = a;
    DIV_divisor  = b;
    DIV_start    = 1'b1;
    set_exp(op, a, b, r);
    @(posedge SYS_clk); #1;
    acc_cyc   = cyc;
    DIV_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!DIV_done && n < 80) begin
      @(posedge SYS_clk); #1;
      n++;
    end
    chk({name, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
    chk({name, "_busy_at_done"}, {31'd0, DIV_busy}, 32'd1);
    @(posedge SYS_clk); #1;
    chk({name, "_busy_fall"}, {31'd0, DIV_busy}, 32'd0);
    chk({name, "_done_fall"}, {31'd0, DIV_done}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    #1;
    chk("reset_busy", {31'd0, DIV_busy}, 32'd0);
    chk("reset_done", {31'd0, DIV_done}, 32'd0);
    chk("reset_result", DIV_result, 32'd0);
    @(negedge SYS_clk); #2;
    SYS_reset = 1'b0;
    @(posedge SYS_clk); #1;

    issue(2'd1, 32'd100, 32'd7, 32'd14);                     wait_done("divu_100_7");
    issue(2'd3, 32'd100, 32'd7, 32'd2);                      wait_done("remu_100_7");
    issue(2'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);        wait_done("divu_max_1");
    issue(2'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);        wait_done("div_m7_2");
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);        wait_done("rem_m7_2");
    issue(2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);        wait_done("div_7_m2");
    issue(2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1);                wait_done("rem_7_m2");
    issue(2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF);                wait_done("div_by0");
    issue(2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF);                wait_done("divu_by0");
    issue(2'd2, 32'd5, 32'd0, 32'd5);                        wait_done("rem_by0");
    issue(2'd3, 32'd5, 32'd0, 32'd5);                        wait_done("remu_by0");
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_done("div_ovf");
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);        wait_done("rem_ovf");
    issue(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);        wait_done("divu_ovf_ops");
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_done("remu_ovf_ops");

    // New start with different operands mid-run must be ignored.
    issue(2'd1, 32'd100, 32'd7, 32'd14);
    repeat (5) @(posedge SYS_clk);
    #1;
    DIV_op = 2'd3; DIV_dividend = 32'd1; DIV_divisor = 32'd0; DIV_start = 1'b1;
    @(posedge SYS_clk); #1;
    DIV_start = 1'b0;
    wait_done("start_in_run");

    // Cancel on the tenth iteration: no done, result keeps 14.
    issue(2'd1, 32'd50, 32'd3, 32'd16);
    repeat (9) @(posedge SYS_clk);
    #1;
    DIV_cancel = 1'b1;
    @(posedge SYS_clk); #1;
    chk("cancel_busy", {31'd0, DIV_busy}, 32'd0);
    chk("cancel_done", {31'd0, DIV_done}, 32'd0);
    exp_pending = 1'b0;
    DIV_start = 1'b1; DIV_op = 2'd1; DIV_dividend = 32'd9; DIV_divisor = 32'd3;
    @(posedge SYS_clk); #1;
    chk("cancel_beats_start", {31'd0, DIV_busy}, 32'd0);
    DIV_start = 1'b0;
    @(posedge SYS_clk); #1;
    DIV_cancel = 1'b0;
    chk("cancel_idle_busy", {31'd0, DIV_busy}, 32'd0);
    repeat (40) @(posedge SYS_clk);
    #1;
    chk("cancel_result_kept", DIV_result, 32'd14);

    // Start held through RUN and DONE: one accept per op, next accept right after DONE.
    issue(2'd1, 32'd100, 32'd7, 32'd14);
    DIV_start = 1'b1; DIV_op = 2'd1; DIV_dividend = 32'd9; DIV_divisor = 32'd3;
    wait_done("b2b_first");
    set_exp(2'd1, 32'd9, 32'd3, 32'd3);
    @(posedge SYS_clk); #1;
    acc_cyc   = cyc;
    DIV_start = 1'b0;
    wait_done("b2b_second");

    // Asynchronous reset between edges clears outputs before the next edge.
    issue(2'd1, 32'd100, 32'd7, 32'd14);
    repeat (6) @(posedge SYS_clk);
    #3;
    SYS_reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, DIV_busy}, 32'd0);
    chk("arst_done", {31'd0, DIV_done}, 32'd0);
    chk("arst_result", DIV_result, 32'd0);
    held = 32'd0;
    exp_pending = 1'b0;
    @(negedge SYS_clk); #1;
    SYS_reset = 1'b0;
    @(posedge SYS_clk); #1;
    chk("arst_idle", {31'd0, DIV_busy}, 32'd0);

    repeat (40) begin
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      issue(op, a, b, model(op, a, b));
      wait_done("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
